// File: rtl/pwchk_pkg.sv
// Shared constants and state encoding for the password checker and its storage block.
package pwchk_pkg;

   localparam int PW_ADDR_W = 4;
   localparam int PW_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      RESULT = 2'd2,
      LOCKED = 2'd3
   } pwchk_state_e;

endpackage

// File: rtl/pwchk_lockout.sv
// Consecutive-failure counter and timed lockout for the password checker.
// A deny that brings the count to MAX_FAILS starts a LOCK_CYCLES lockout,
// and the count clears when the lockout ends.
module pwchk_lockout #(
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 16,
   parameter int FC_W        = $clog2(MAX_FAILS + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            grant_i,
   input  logic            deny_i,
   output logic [FC_W-1:0] fail_count_o,
   output logic            lock_start_o,
   output logic            locked_o,
   output logic            lock_end_o
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);

   logic [FC_W-1:0] fail_count_q;
   logic [LW-1:0]   lock_cnt_q;
   logic            locked_q;

   // The deny that reaches the limit starts the lockout on the following edge.
   assign lock_start_o = deny_i && ((fail_count_q + 1'b1) == FC_W'(MAX_FAILS));
   // Last locked cycle: the checker leaves LOCKED on this edge.
   assign lock_end_o   = locked_q && (lock_cnt_q == LW'(1));
   assign locked_o     = locked_q;
   assign fail_count_o = fail_count_q;

   // Fail counter and lockout down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_count_q <= '0;
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
      end else begin
         if (grant_i) begin
            fail_count_q <= '0;
         end else if (deny_i) begin
            fail_count_q <= fail_count_q + 1'b1;
         end
         if (lock_start_o) begin
            locked_q   <= 1'b1;
            lock_cnt_q <= LW'(LOCK_CYCLES);
         end else if (locked_q) begin
            if (lock_cnt_q == LW'(1)) begin
               locked_q     <= 1'b0;
               lock_cnt_q   <= '0;
               fail_count_q <= '0;
            end else begin
               lock_cnt_q <= lock_cnt_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/password_checker.sv
// Password checker: compares entered characters beat by beat against the
// password storage (combinational read at idx), issues a one-cycle grant/deny
// the cycle after the last beat, and hands verdicts to the lockout block.
// Optional build macro PWCHK_TIMEOUT_EN adds an inter-character idle timeout
// in ENTRY; without it ENTRY waits indefinitely.
module password_checker
   import pwchk_pkg::*;
#(
   parameter int PW_LEN         = 10,
   parameter int MAX_FAILS      = 3,
   parameter int LOCK_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int FC_W           = $clog2(MAX_FAILS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PW_DATA_W-1:0] in_data,
   input  logic                 in_last,
   output logic [PW_ADDR_W-1:0] mem_read_addr,
   input  logic [PW_DATA_W-1:0] mem_read_data,
   output logic                 grant,
   output logic                 deny,
   output logic                 locked,
   output logic [FC_W-1:0]      fail_count
);

   pwchk_state_e         state_q;
   logic [PW_ADDR_W-1:0] idx_q, idx_d;
   logic                 mismatch_q, mismatch_d;
   logic                 grant_q, deny_q;
   logic                 accept, overlen, last_ok, timeout;
   logic                 lock_start, lock_end;

   assign in_ready      = (state_q == IDLE) || (state_q == ENTRY);
   assign accept        = in_valid && in_ready;
   assign mem_read_addr = idx_q;
   assign grant         = grant_q;
   assign deny          = deny_q;

   // A beat past the stored length never matches; storage data is ignored there.
   assign overlen    = (idx_q == PW_ADDR_W'(PW_LEN));
   assign mismatch_d = mismatch_q || overlen || (in_data != mem_read_data);
   assign idx_d      = overlen ? idx_q : idx_q + 1'b1;
   // Grant needs a clean run ending exactly on the PW_LEN-th beat.
   assign last_ok    = !mismatch_d && (idx_q == PW_ADDR_W'(PW_LEN - 1));

`ifdef PWCHK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle in ENTRY.
   assign timeout = (state_q == ENTRY) && !accept && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: runs only in ENTRY, cleared by every accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else if ((state_q != ENTRY) || accept) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign timeout        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   // Main FSM with registered verdict pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         grant_q    <= 1'b0;
         deny_q     <= 1'b0;
      end else begin
         grant_q <= 1'b0;
         deny_q  <= 1'b0;
         case (state_q)
            IDLE, ENTRY: begin
               if (accept) begin
                  if (in_last) begin
                     grant_q    <= last_ok;
                     deny_q     <= !last_ok;
                     idx_q      <= '0;
                     mismatch_q <= 1'b0;
                     state_q    <= RESULT;
                  end else begin
                     idx_q      <= idx_d;
                     mismatch_q <= mismatch_d;
                     state_q    <= ENTRY;
                  end
               end else if (timeout) begin
                  deny_q     <= 1'b1;
                  idx_q      <= '0;
                  mismatch_q <= 1'b0;
                  state_q    <= RESULT;
               end
            end
            RESULT:  state_q <= lock_start ? LOCKED : IDLE;
            LOCKED:  if (lock_end) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   pwchk_lockout #(
      .MAX_FAILS   (MAX_FAILS),
      .LOCK_CYCLES (LOCK_CYCLES),
      .FC_W        (FC_W)
   ) u_lockout (
      .clk          (clk),
      .rst_n        (rst_n),
      .grant_i      (grant_q),
      .deny_i       (deny_q),
      .fail_count_o (fail_count),
      .lock_start_o (lock_start),
      .locked_o     (locked),
      .lock_end_o   (lock_end)
   );

endmodule

// File: tb/tb_password_checker.sv
// Bench for password_checker: directed scenarios plus randomized attempts,
// judged by a model that compares whole attempts against the stored password.
module tb_password_checker;
   import pwchk_pkg::*;

   localparam int PW_LEN      = 10;
   localparam int MAX_FAILS   = 3;
   localparam int LOCK_CYCLES = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic [3:0] mem_read_addr;
   logic [7:0] mem_read_data;
   logic       grant, deny, locked;
   logic [1:0] fail_count;

   logic [7:0] pw [0:9];
   int checks = 0;
   int errors = 0;
   int exp_fc = 0;

   always #5 clk = ~clk;

   // Storage model: combinational read, zero beyond the stored entries.
   assign mem_read_data = (mem_read_addr < 4'd10) ? pw[mem_read_addr] : 8'h00;

   password_checker #(
      .PW_LEN(PW_LEN), .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data), .grant(grant), .deny(deny),
      .locked(locked), .fail_count(fail_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Invariants sampled every cycle on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("grant_and_deny", {31'd0, grant && deny}, 0);
         chk("fc_bound", {31'd0, fail_count > 2'(MAX_FAILS)}, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] ch, input bit last, input int pos);
      in_valid = 1'b1;
      in_data  = ch;
      in_last  = last;
      chk("in_ready", in_ready, 1);
      chk("rd_addr", mem_read_addr, (pos < PW_LEN) ? pos : PW_LEN);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
   endtask

   function automatic bit model_grant(input logic [7:0] a[$]);
      if (a.size() != PW_LEN) return 1'b0;
      foreach (a[i]) if (a[i] !== pw[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Called in the verdict cycle; follows through any lockout.
   task automatic verdict(input bit exp_g);
      chk("grant", grant, exp_g);
      chk("deny", deny, !exp_g);
      chk("rdy_result", in_ready, 0);
      chk("fc_hold", fail_count, exp_fc);
      if (exp_g) exp_fc = 0; else exp_fc++;
      tick();
      chk("pulse_end", {grant, deny}, 0);
      chk("fail_count", fail_count, exp_fc);
      chk("addr_idle", mem_read_addr, 0);
      if (exp_fc == MAX_FAILS) begin
         int n = 0;
         for (int k = 0; k < 100 && locked; k++) begin
            n++;
            chk("rdy_lock", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_last  = 1'($urandom_range(0, 1));
            tick();
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk("lock_len", n, LOCK_CYCLES);
         exp_fc = 0;
         chk("fc_unlock", fail_count, 0);
         chk("rdy_unlock", in_ready, 1);
      end else begin
         chk("locked", locked, 0);
      end
   endtask

   task automatic attempt(input logic [7:0] a[$]);
      foreach (a[i]) send_beat(a[i], i == a.size() - 1, i);
      verdict(model_grant(a));
   endtask

   function automatic void make_good(output logic [7:0] q[$]);
      q = {};
      for (int i = 0; i < PW_LEN; i++) q.push_back(pw[i]);
   endfunction

   initial begin
      logic [7:0] a[$];
      bit bad;
      for (int i = 0; i < 10; i++) pw[i] = 8'h41 + 8'(i);

      // Reset state
      repeat (3) tick();
      chk("rst_grant", grant, 0);
      chk("rst_deny", deny, 0);
      chk("rst_locked", locked, 0);
      chk("rst_fc", fail_count, 0);
      chk("rst_addr", mem_read_addr, 0);
      chk("rst_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // Directed: correct, bad beat 5, short, long (ends in lockout)
      make_good(a); attempt(a);
      make_good(a); a[4] = 8'h00; attempt(a);
      make_good(a); void'(a.pop_back()); attempt(a);
      make_good(a); a.push_back(8'h4B); attempt(a);

      // Three consecutive wrong attempts, then a correct one
      for (int t = 0; t < 3; t++) begin
         make_good(a);
         a[$urandom_range(0, 9)] ^= 8'($urandom_range(1, 255));
         attempt(a);
      end
      make_good(a); attempt(a);

      // Asynchronous reset mid-attempt discards the attempt
      make_good(a); a[0] = 8'h00; attempt(a);
      make_good(a);
      for (int i = 0; i < 4; i++) send_beat(a[i], 1'b0, i);
      #2 rst_n = 1'b0;
      #1;
      exp_fc = 0;
      chk("arst_addr", mem_read_addr, 0);
      chk("arst_verdict", {grant, deny}, 0);
      chk("arst_locked", locked, 0);
      chk("arst_fc", fail_count, 0);
      tick();
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (3) begin tick(); if (grant || deny) bad = 1'b1; end
      chk("arst_stray", bad, 0);
      attempt(a);

      // Idle inside an attempt
      for (int i = 0; i < 3; i++) send_beat(a[i], 1'b0, i);
`ifdef PWCHK_TIMEOUT_EN
      bad = 1'b0;
      for (int k = 1; k < 64; k++) begin tick(); if (grant || deny) bad = 1'b1; end
      chk("to_early", bad, 0);
      tick();
      verdict(1'b0);
      chk("to_fc", fail_count, 1);
      make_good(a); attempt(a);
`else
      bad = 1'b0;
      repeat (200) begin tick(); if (grant || deny || !in_ready) bad = 1'b1; end
      chk("idle_wait", bad, 0);
      for (int i = 3; i < PW_LEN; i++) send_beat(a[i], i == PW_LEN - 1, i);
      verdict(1'b1);
`endif

      // Randomized attempts
      for (int t = 0; t < 40; t++) begin
         int kind, len;
         kind = $urandom_range(0, 4);
         make_good(a);
         case (kind)
            1: a[$urandom_range(0, 9)] ^= 8'($urandom_range(1, 255));
            2: begin
               len = $urandom_range(1, 9);
               while (a.size() > len) void'(a.pop_back());
            end
            3: repeat ($urandom_range(1, 2)) a.push_back(8'($urandom));
            4: begin
               len = $urandom_range(1, 12);
               a = {};
               repeat (len) a.push_back(8'($urandom));
            end
            default: ;
         endcase
         repeat ($urandom_range(0, 3)) tick();
         attempt(a);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
